multicycle_control_unit: RTL and testbench

//  Multicycle MIPS control FSM; next generation of the single-cycle decoder.

---
 rtl/multicycle_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences each instruction through FETCH/DECODE/execute states.
// Optional `ILLEGAL_TRAP_EN: illegal op/func parks the FSM in TRAP with illegal=1 until reset.
module multicycle_control_unit #(
  parameter int OP_W     = 6,
  parameter int FUNC_W   = 6,
  parameter int ALUCTR_W = 4,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNC_W-1:0]   func,
  input  logic                mem_ready,
  output logic                PCWr,
  output logic                PCWrCond,
  output logic                IorD,
  output logic                MemRd,
  output logic                MemWr,
  output logic                IRWr,
  output logic                RegWr,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic                Extop,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                instr_done,
  output logic                illegal,
  output logic [STATE_W-1:0]  state_o
);

  // Memory handshake: a MemRd/MemWr request stays asserted, unchanged, until the
  // cycle in which mem_ready=1; that cycle completes the access and the FSM moves on.
  // mem_ready has no effect in any other state.

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_FETCH  = STATE_W'(0);
  localparam state_t S_DECODE = STATE_W'(1);
  localparam state_t S_EXEC_R = STATE_W'(2);
  localparam state_t S_ALUWB  = STATE_W'(3);
  localparam state_t S_MEMADR = STATE_W'(4);
  localparam state_t S_MEMRD  = STATE_W'(5);
  localparam state_t S_MEMWB  = STATE_W'(6);
  localparam state_t S_MEMWR  = STATE_W'(7);
  localparam state_t S_BRANCH = STATE_W'(8);
  localparam state_t S_JUMP   = STATE_W'(9);
  localparam state_t S_EXEC_I = STATE_W'(10);
  localparam state_t S_IWB    = STATE_W'(11);
`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_TRAP   = STATE_W'(12);
`endif

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);

  localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(6'b100010);
  localparam logic [FUNC_W-1:0] FN_AND = FUNC_W'(6'b100100);
  localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(6'b100101);
  localparam logic [FUNC_W-1:0] FN_SLT = FUNC_W'(6'b101010);

  localparam logic [ALUCTR_W-1:0] ALU_AND = ALUCTR_W'(4'b0000);
  localparam logic [ALUCTR_W-1:0] ALU_OR  = ALUCTR_W'(4'b0001);
  localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(4'b0010);
  localparam logic [ALUCTR_W-1:0] ALU_SUB = ALUCTR_W'(4'b0110);
  localparam logic [ALUCTR_W-1:0] ALU_SLT = ALUCTR_W'(4'b0111);

  state_t state, state_nxt;

  // Where an illegal op/func sends the FSM.
`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_ILLEGAL = S_TRAP;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  // R-type function decode; unknown functions fall back to ADD and are flagged.
  logic                func_legal;
  logic [ALUCTR_W-1:0] func_aluctr;
  always_comb begin
    func_legal  = 1'b1;
    func_aluctr = ALU_ADD;
    case (func)
      FN_ADD:  func_aluctr = ALU_ADD;
      FN_SUB:  func_aluctr = ALU_SUB;
      FN_AND:  func_aluctr = ALU_AND;
      FN_OR:   func_aluctr = ALU_OR;
      FN_SLT:  func_aluctr = ALU_SLT;
      default: func_legal  = 1'b0;
    endcase
  end

  logic op_legal;
  always_comb begin
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: op_legal = 1'b1;
      default:                                           op_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_R:           state_nxt = S_EXEC_R;
          OP_LW, OP_SW:   state_nxt = S_MEMADR;
          OP_BEQ:         state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          OP_ADDI, OP_ORI: state_nxt = S_EXEC_I;
          default:        state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_nxt = func_legal ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:  state_nxt = S_FETCH;
      S_MEMADR: state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_EXEC_I: state_nxt = S_IWB;
      S_IWB:    state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_nxt = S_TRAP;
`endif
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output logic; reset forces every output low in the same cycle.
  always_comb begin
    PCWr       = 1'b0;
    PCWrCond   = 1'b0;
    IorD       = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    Extop      = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUctr     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state_o    = state;
    case (state)
      S_FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Extop   = 1'b1;
`ifndef ILLEGAL_TRAP_EN
        instr_done = ~op_legal;
`endif
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUctr  = func_aluctr;
`ifndef ILLEGAL_TRAP_EN
        instr_done = ~func_legal;
`endif
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Extop   = 1'b1;
      end
      S_MEMRD: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWr      = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUctr     = ALU_SUB;
        PCWrCond   = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWr       = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
      end
      S_EXEC_I, S_IWB: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUctr  = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        Extop   = (op == OP_ADDI);
        if (state == S_IWB) begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      PCWr       = 1'b0;
      PCWrCond   = 1'b0;
      IorD       = 1'b0;
      MemRd      = 1'b0;
      MemWr      = 1'b0;
      IRWr       = 1'b0;
      RegWr      = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      Extop      = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      ALUctr     = '0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      state_o    = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into its
// expected per-cycle control vectors (with memory waits) and compared cycle by cycle.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcwr, pcwrcond, iord, memrd, memwr, irwr, regwr, regdst, memtoreg, alusrca, extop;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluctr;
    logic       instr_done, illegal;
  } ctl_t;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000,
                         O_ORI = 6'b001101;
`ifdef ILLEGAL_TRAP_EN
  localparam bit trap_mode = 1'b1;
`else
  localparam bit trap_mode = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] op, func;
  logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg, ALUSrcA, Extop;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUctr, state_o;
  logic       instr_done, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] exp_q[$];
  logic        mr_q[$];

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
    .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .Extop(Extop), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUctr(ALUctr), .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic ctl_t obs_vec();
    return {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg,
            ALUSrcA, Extop, ALUSrcB, PCSrc, ALUctr, instr_done, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input ctl_t e, input logic mr);
    exp_q.push_back(e);
    mr_q.push_back(mr);
  endfunction

  // R-type function table
  function automatic void r_func(input logic [5:0] f, output logic [3:0] c, output logic ok);
    ok = 1'b1;
    c  = A_ADD;
    case (f)
      6'b100000: c = A_ADD;
      6'b100010: c = A_SUB;
      6'b100100: c = A_AND;
      6'b100101: c = A_OR;
      6'b101010: c = A_SLT;
      default:   ok = 1'b0;
    endcase
  endfunction

  // Last cycle of an illegal instruction, followed by the trap cycles when trapping.
  function automatic void illegal_tail(input ctl_t last);
    ctl_t t;
    if (trap_mode) begin
      push(last, rnd_bit());
      t = '0;
      t.aluctr  = A_ADD;
      t.illegal = 1'b1;
      for (int i = 0; i < 4; i++) push(t, rnd_bit());
    end else begin
      last.instr_done = 1'b1;
      push(last, rnd_bit());
    end
  endfunction

  // Expand one instruction into expected cycles; fw/mw are memory wait cycles.
  function automatic void push_instr(input logic [5:0] o, input logic [5:0] f,
                                     input int fw, input int mw);
    ctl_t e, dec;
    logic [3:0] fc;
    logic       fok;
    e = '0; e.memrd = 1; e.alusrcb = 2'b01; e.aluctr = A_ADD;
    for (int i = 0; i < fw; i++) push(e, 1'b0);
    e.irwr = 1; e.pcwr = 1;
    push(e, 1'b1);
    dec = '0; dec.alusrcb = 2'b11; dec.extop = 1; dec.aluctr = A_ADD;
    case (o)
      O_R: begin
        push(dec, rnd_bit());
        r_func(f, fc, fok);
        e = '0; e.alusrca = 1; e.aluctr = fc;
        if (fok) begin
          push(e, rnd_bit());
          e = '0; e.regdst = 1; e.regwr = 1; e.instr_done = 1; e.aluctr = A_ADD;
          push(e, rnd_bit());
        end else illegal_tail(e);
      end
      O_LW, O_SW: begin
        push(dec, rnd_bit());
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.extop = 1; e.aluctr = A_ADD;
        push(e, rnd_bit());
        e = '0; e.iord = 1; e.aluctr = A_ADD;
        if (o == O_LW) e.memrd = 1; else e.memwr = 1;
        for (int i = 0; i < mw; i++) push(e, 1'b0);
        if (o == O_SW) e.instr_done = 1;
        push(e, 1'b1);
        if (o == O_LW) begin
          e = '0; e.memtoreg = 1; e.regwr = 1; e.instr_done = 1; e.aluctr = A_ADD;
          push(e, rnd_bit());
        end
      end
      O_BEQ: begin
        push(dec, rnd_bit());
        e = '0; e.alusrca = 1; e.aluctr = A_SUB; e.pcwrcond = 1; e.pcsrc = 2'b01;
        e.instr_done = 1;
        push(e, rnd_bit());
      end
      O_J: begin
        push(dec, rnd_bit());
        e = '0; e.pcwr = 1; e.pcsrc = 2'b10; e.instr_done = 1; e.aluctr = A_ADD;
        push(e, rnd_bit());
      end
      O_ADDI, O_ORI: begin
        push(dec, rnd_bit());
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        e.aluctr = (o == O_ORI) ? A_OR : A_ADD;
        e.extop  = (o == O_ADDI);
        push(e, rnd_bit());
        e.regwr = 1; e.instr_done = 1;
        push(e, rnd_bit());
      end
      default: illegal_tail(dec);
    endcase
  endfunction

  // Driver: consume up to n expected cycles with op/func held.
  task automatic run_n(input string tag, input logic [5:0] o, input logic [5:0] f, input int n);
    ctl_t e;
    op = o; func = f;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(obs_vec()), 32'(e));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input int fw, input int mw);
    push_instr(o, f, fw, mw);
    run_n(tag, o, f, exp_q.size());
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_outputs", {7'b0, state_o, obs_vec()}, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[5];
    logic [5:0] o, f;
    ops = '{O_R, O_LW, O_SW, O_BEQ, O_J, O_ADDI, O_ORI};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1; mem_ready = 1'b1; op = '0; func = '0;
    @(posedge clk); #1;
    do_reset(3);

    run_instr("sub", O_R, 6'b100010, 0, 0);
    run_instr("lw_wait", O_LW, 6'b0, 0, 2);
    run_instr("beq", O_BEQ, 6'b0, 0, 0);
    run_instr("j", O_J, 6'b0, 0, 0);
    run_instr("ori", O_ORI, 6'b0, 0, 0);
    run_instr("illegal_op", 6'b111111, 6'b0, 0, 0);
    if (trap_mode) do_reset(2);

    // Reset while a store waits on memory
    push_instr(O_SW, 6'b0, 0, 3);
    run_n("sw_abort", O_SW, 6'b0, 4);
    exp_q.delete(); mr_q.delete();
    mem_ready = 1'b0;
    do_reset(1);
    run_instr("after_abort", O_ADDI, 6'b0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      if (!trap_mode && $urandom_range(0, 9) == 0) begin
        o = 6'($urandom);
        f = 6'($urandom);
      end else begin
        o = ops[$urandom_range(0, 6)];
        if (!trap_mode && $urandom_range(0, 4) == 0) f = 6'($urandom);
        else f = fns[$urandom_range(0, 4)];
      end
      if (trap_mode && o == O_R) f = fns[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d_op%02h", k, o), o, f,
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
